// File: rtl/frodo_ctrl_pkg.sv
// Shared types and constants for the frodo sequencing controller.
// Instruction fields are packed MSB-first: opcode, idxA, idxB, idxC, n_inner, n_outer.
package frodo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int OP_W          = 3;
    localparam int IDX_W         = 4;
    localparam int OUTER_W       = 4;
    localparam int DECODE_CYCLES = 4;

    localparam int OP_MODE = 0;
    localparam int OP_SIGN = 1;
    localparam int OP_WB   = 2;

    // Index slots counted up from n_inner: 0 = idxC, 1 = idxB, 2 = idxA.
    function automatic int idx_lsb(input int loop_w, input int slot);
        return OUTER_W + loop_w + slot * IDX_W;
    endfunction

    function automatic int opc_lsb(input int loop_w);
        return OUTER_W + loop_w + 3 * IDX_W;
    endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Two-level loop counters and operand/result address generation.
// Offsets wrap inside a bank; the bank bits of each base pass through untouched.
module seq_addr_gen
    import frodo_ctrl_pkg::*;
#(
    parameter  int ADDR_WIDTH = 12,
    parameter  int BANK_W     = 2,
    parameter  int LOOP_WIDTH = 8,
    localparam int AW         = BANK_W + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  issue,
    input  logic [LOOP_WIDTH-1:0] n_inner,
    input  logic [OUTER_W-1:0]    n_outer,
    input  logic [AW-1:0]         base_a,
    input  logic [AW-1:0]         base_b,
    input  logic [AW-1:0]         base_d,
    output logic [AW-1:0]         rd_addr_a,
    output logic [AW-1:0]         rd_addr_b,
    output logic [AW-1:0]         wr_tag,
    output logic                  mac_clr,
    output logic                  row_last,
    output logic                  op_last
);

    logic [LOOP_WIDTH-1:0] i_q;
    logic [OUTER_W-1:0]    o_q;
    // Running o*n_inner+i, so the B address needs no multiplier.
    logic [ADDR_WIDTH-1:0] k_q;

    assign row_last = (i_q == n_inner - LOOP_WIDTH'(1));
    assign op_last  = row_last && (o_q == n_outer - OUTER_W'(1));
    assign mac_clr  = issue && (i_q == '0);

    assign rd_addr_a = {base_a[AW-1 -: BANK_W], base_a[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i_q)};
    assign rd_addr_b = {base_b[AW-1 -: BANK_W], base_b[ADDR_WIDTH-1:0] + k_q};
    assign wr_tag    = {base_d[AW-1 -: BANK_W], base_d[ADDR_WIDTH-1:0] + ADDR_WIDTH'(o_q)};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            o_q <= '0;
            k_q <= '0;
        end else if (load) begin
            i_q <= '0;
            o_q <= '0;
            k_q <= '0;
        end else if (issue) begin
            k_q <= k_q + ADDR_WIDTH'(1);
            if (row_last) begin
                i_q <= '0;
                o_q <= o_q + OUTER_W'(1);
            end else begin
                i_q <= i_q + LOOP_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/frodo_seq_ctrl.sv
// Instruction sequencer: descriptor fetch, outer x inner MAC issue with stall,
// and a fixed-latency write strobe into a bank-interleaved result memory.
module frodo_seq_ctrl
    import frodo_ctrl_pkg::*;
#(
    parameter  int ADDR_WIDTH = 12,
    parameter  int NUM_BANKS  = 4,
    parameter  int LOOP_WIDTH = 8,
    parameter  int PIPE_LAT   = 3,
    localparam int BANK_W     = $clog2(NUM_BANKS),
    localparam int INST_WIDTH = 19 + LOOP_WIDTH,
    localparam int AW         = BANK_W + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic                  stall,
    output logic                  tbl_en,
    output logic [IDX_W-1:0]      tbl_addr,
    input  logic [AW-1:0]         tbl_data,
    output logic [AW-1:0]         rd_addr_a,
    output logic [AW-1:0]         rd_addr_b,
    output logic [AW-1:0]         wr_addr,
    output logic [NUM_BANKS-1:0]  wr_en,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  macs_mode,
    output logic                  macs_signal,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DCW = $clog2(DECODE_CYCLES);
    localparam int DRW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t                state_q, state_d;
    logic [DCW-1:0]        dcnt_q;
    logic [DRW-1:0]        drain_q;
    logic [OP_W-1:0]       op_q;
    logic [LOOP_WIDTH-1:0] n_inner_q;
    logic [OUTER_W-1:0]    n_outer_q;
    logic [IDX_W-1:0]      idx_a_q, idx_b_q, idx_c_q;
    logic [AW-1:0]         base_a_q, base_b_q, base_d_q;
    logic                  err_q;

    logic                  accept, bad_inst, issue;
    logic                  row_last, op_last;
    logic [AW-1:0]         wr_tag;
    logic                  pipe_vld [PIPE_LAT];
    logic [AW-1:0]         pipe_tag [PIPE_LAT];

    logic [LOOP_WIDTH-1:0] f_inner;
    logic [OUTER_W-1:0]    f_outer;

    assign f_outer  = inst[OUTER_W-1:0];
    assign f_inner  = inst[OUTER_W +: LOOP_WIDTH];
    assign bad_inst = (f_inner == '0) || (f_outer == '0);
    assign accept   = inst_valid && (state_q == ST_IDLE);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        busy       = 1'b1;
        tbl_en     = 1'b0;
        tbl_addr   = '0;
        done       = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
                if (inst_valid) state_d = bad_inst ? ST_DONE : ST_DECODE;
            end
            ST_DECODE: begin
                tbl_en = (dcnt_q != DCW'(DECODE_CYCLES - 1));
                case (dcnt_q)
                    DCW'(0): tbl_addr = idx_a_q;
                    DCW'(1): tbl_addr = idx_b_q;
                    DCW'(2): tbl_addr = idx_c_q;
                    default: tbl_addr = '0;
                endcase
                if (dcnt_q == DCW'(DECODE_CYCLES - 1)) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                issue = !stall;
                if (issue && op_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DRW'(PIPE_LAT - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            drain_q   <= '0;
            op_q      <= '0;
            n_inner_q <= '0;
            n_outer_q <= '0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            idx_c_q   <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_d_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= (state_q == ST_DECODE) ? dcnt_q + DCW'(1) : '0;
            drain_q <= (state_q == ST_DRAIN) ? drain_q + DRW'(1) : '0;
            if (accept) begin
                op_q      <= inst[opc_lsb(LOOP_WIDTH) +: OP_W];
                idx_a_q   <= inst[idx_lsb(LOOP_WIDTH, 2) +: IDX_W];
                idx_b_q   <= inst[idx_lsb(LOOP_WIDTH, 1) +: IDX_W];
                idx_c_q   <= inst[idx_lsb(LOOP_WIDTH, 0) +: IDX_W];
                n_inner_q <= f_inner;
                n_outer_q <= f_outer;
                err_q     <= bad_inst;
            end
            // Table data lags the request by one cycle.
            if (state_q == ST_DECODE) begin
                case (dcnt_q)
                    DCW'(1): base_a_q <= tbl_data;
                    DCW'(2): base_b_q <= tbl_data;
                    DCW'(3): base_d_q <= tbl_data ^ (AW'(1) << ADDR_WIDTH);
                    default: ;
                endcase
            end
        end
    end

    seq_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_W     (BANK_W),
        .LOOP_WIDTH (LOOP_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .issue     (issue),
        .n_inner   (n_inner_q),
        .n_outer   (n_outer_q),
        .base_a    (base_a_q),
        .base_b    (base_b_q),
        .base_d    (base_d_q),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_tag    (wr_tag),
        .mac_clr   (mac_clr),
        .row_last  (row_last),
        .op_last   (op_last)
    );

    // NOTE: the write pipe is a handful of flops, so it is reset; that drops pending writes on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_tag[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue && row_last && op_q[OP_WB];
            pipe_tag[0] <= (issue && row_last && op_q[OP_WB]) ? wr_tag : '0;
            for (int k = 1; k < PIPE_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    always_comb begin
        wr_en = '0;
        if (pipe_vld[PIPE_LAT-1]) wr_en = NUM_BANKS'(1) << pipe_tag[PIPE_LAT-1][AW-1 -: BANK_W];
    end

    assign wr_addr     = pipe_tag[PIPE_LAT-1];
    assign mac_en      = issue;
    assign macs_mode   = op_q[OP_MODE];
    assign macs_signal = op_q[OP_SIGN];
    assign err         = done && err_q;

endmodule

// File: tb/tb_frodo_seq_ctrl.sv
// Scoreboard bench for frodo_seq_ctrl: expected issues and writes are queued
// when an instruction is driven and popped as the DUT produces them.
module tb_frodo_seq_ctrl;

    localparam int AWID = 12;
    localparam int NB   = 4;
    localparam int LW   = 8;
    localparam int PL   = 3;
    localparam int AW   = 14;
    localparam int IW   = 19 + LW;

    logic          clk;
    logic          rst;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    logic          stall;
    logic          tbl_en;
    logic [3:0]    tbl_addr;
    logic [AW-1:0] tbl_data;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [NB-1:0] wr_en;
    logic          mac_en, mac_clr, macs_mode, macs_signal;
    logic          busy, done, err;

    frodo_seq_ctrl #(
        .ADDR_WIDTH (AWID),
        .NUM_BANKS  (NB),
        .LOOP_WIDTH (LW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .stall       (stall),
        .tbl_en      (tbl_en),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .mac_en      (mac_en),
        .mac_clr     (mac_clr),
        .macs_mode   (macs_mode),
        .macs_signal (macs_signal),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Descriptor table: synchronous read, data valid the cycle after tbl_en.
    logic [AW-1:0] tbl_mem [16];
    always @(posedge clk) tbl_data <= tbl_en ? tbl_mem[tbl_addr] : '0;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          clr;
        int            cyc;
    } iss_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [NB-1:0] en;
        int            cyc;
    } wr_t;

    iss_t iss_q[$];
    wr_t  wr_q[$];
    int   n_vec;
    int   n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] off_add(input logic [AW-1:0] base, input int off);
        int sum;
        sum = (int'(base[AWID-1:0]) + off) % 4096;
        return {base[AW-1:AWID], 12'(sum)};
    endfunction

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                          input int ni, input int no, input int sa, input int sl_in);
        logic [AW-1:0] ba, bb, bc, bd;
        int   n, j, sl, exp_done, c, tbl_cnt;
        logic exp_err;
        bit   fin;
        iss_t e;
        wr_t  w;

        ba = tbl_mem[ia];
        bb = tbl_mem[ib];
        bc = tbl_mem[ic];
        bd = {bc[AW-1], ~bc[AW-2], bc[AWID-1:0]};
        exp_err = (ni == 0) || (no == 0);
        n  = ni * no;
        sl = (sa < n) ? sl_in : 0;
        iss_q.delete();
        wr_q.delete();
        if (!exp_err) begin
            for (int o = 0; o < no; o++) begin
                for (int i = 0; i < ni; i++) begin
                    j     = o * ni + i + 1;
                    e.a   = off_add(ba, i);
                    e.b   = off_add(bb, o * ni + i);
                    e.clr = (i == 0);
                    e.cyc = 4 + j + ((j > sa) ? sl : 0);
                    iss_q.push_back(e);
                    if (i == ni - 1 && op[2]) begin
                        w.addr = off_add(bd, o);
                        w.en   = 4'b0001 << bd[AW-1:AWID];
                        w.cyc  = e.cyc + PL;
                        wr_q.push_back(w);
                    end
                end
            end
            exp_done = 5 + n + PL + sl;
        end else begin
            exp_done = 1;
        end

        @(negedge clk);
        inst       = {op, ia, ib, ic, 8'(ni), 4'(no)};
        inst_valid = 1'b1;
        check({nm, " ready_idle"}, 32'(inst_ready), 32'd1);
        @(posedge clk);
        c       = 0;
        fin     = 1'b0;
        tbl_cnt = 0;
        while (!fin) begin
            #1;
            c++;
            inst_valid = (c <= 3);
            inst       = ~inst;
            stall      = (c > 4 + sa) && (c <= 4 + sa + sl);
            @(negedge clk);
            if (tbl_en) tbl_cnt++;
            if (c == 2 && !exp_err) check({nm, " ready_busy"}, 32'(inst_ready), 32'd0);
            if (mac_en) begin
                if (iss_q.size() == 0) begin
                    check({nm, " extra_mac_cyc"}, 32'(c), 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    check({nm, " rd_a"}, 32'(rd_addr_a), 32'(e.a));
                    check({nm, " rd_b"}, 32'(rd_addr_b), 32'(e.b));
                    check({nm, " clr"}, 32'(mac_clr), 32'(e.clr));
                    check({nm, " issue_cyc"}, 32'(c), 32'(e.cyc));
                end
            end else if (stall && iss_q.size() > 0) begin
                check({nm, " hold_a"}, 32'(rd_addr_a), 32'(iss_q[0].a));
                check({nm, " hold_b"}, 32'(rd_addr_b), 32'(iss_q[0].b));
            end
            if (wr_en != '0) begin
                if (wr_q.size() == 0) begin
                    check({nm, " extra_wr_cyc"}, 32'(c), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check({nm, " wr_addr"}, 32'(wr_addr), 32'(w.addr));
                    check({nm, " wr_en"}, 32'(wr_en), 32'(w.en));
                    check({nm, " wr_cyc"}, 32'(c), 32'(w.cyc));
                end
            end
            if (done) begin
                check({nm, " done_cyc"}, 32'(c), 32'(exp_done));
                check({nm, " err"}, 32'(err), 32'(exp_err));
                check({nm, " busy_done"}, 32'(busy), 32'd1);
                check({nm, " mode_sign"}, 32'({macs_signal, macs_mode}), 32'(op[1:0]));
                fin = 1'b1;
            end else if (c > exp_done + 16) begin
                check({nm, " timeout_cyc"}, 32'(c), 32'(exp_done));
                fin = 1'b1;
            end
            if (!fin) @(posedge clk);
        end
        stall      = 1'b0;
        inst_valid = 1'b0;
        check({nm, " issues_left"}, 32'(iss_q.size()), 32'd0);
        check({nm, " writes_left"}, 32'(wr_q.size()), 32'd0);
        check({nm, " tbl_reads"}, 32'(tbl_cnt), exp_err ? 32'd0 : 32'd3);
        @(negedge clk);
        check({nm, " ready_after"}, 32'({inst_ready, busy, done}), 32'b100);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        inst       = {3'b100, 4'd0, 4'd1, 4'd2, 8'd4, 4'd2};
        inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        // First write of this op lands in cycle 8+PL after the accept edge.
        repeat (8 + PL) @(negedge clk);
        check("rst pre_wr_en", 32'(wr_en), 32'b1000);
        rst = 1'b1;
        #1;
        check("rst ready", 32'(inst_ready), 32'd1);
        check("rst quiet", 32'({wr_en, mac_en, done, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst drained", 32'({wr_en, mac_en, done, tbl_en}), 32'd0);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        inst       = '0;
        inst_valid = 1'b0;
        stall      = 1'b0;
        for (int k = 0; k < 16; k++) tbl_mem[k] = '0;
        tbl_mem[0] = 14'h0010;
        tbl_mem[1] = 14'h1100;
        tbl_mem[2] = 14'h2200;
        tbl_mem[3] = 14'h1FFE;
        tbl_mem[4] = 14'h3FFF;
        tbl_mem[5] = 14'h2FFD;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(inst_ready), 32'd1);
        check("reset status", 32'({busy, done, err, mac_en, mac_clr, tbl_en}), 32'd0);
        check("reset wr", 32'({wr_en, wr_addr}), 32'd0);
        check("reset addr", 32'({rd_addr_a, rd_addr_b}), 32'd0);
        check("reset mode", 32'({macs_mode, macs_signal}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("wb",       3'b100, 4'd0, 4'd1, 4'd2, 4, 2, 100, 0);
        run_op("nowb",     3'b011, 4'd0, 4'd1, 4'd2, 4, 2, 100, 0);
        run_op("stall",    3'b100, 4'd0, 4'd1, 4'd2, 4, 2, 3, 2);
        run_op("zero_in",  3'b100, 4'd0, 4'd1, 4'd2, 0, 2, 100, 0);
        run_op("zero_out", 3'b101, 4'd0, 4'd1, 4'd2, 3, 0, 100, 0);
        run_op("wrap",     3'b000, 4'd3, 4'd1, 4'd4, 4, 1, 100, 0);
        run_op("mix",      3'b110, 4'd5, 4'd3, 4'd4, 3, 5, 7, 1);
        reset_mid();
        run_op("after_rst", 3'b111, 4'd3, 4'd5, 4'd4, 2, 3, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
